// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : 8N1 UART transmitter. Accepts one byte over a valid/ready
//             handshake and shifts it out as start bit, 8 data bits LSB
//             first, and one stop bit. Line idles high.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1  system clock, rising edge
//    clr       in   1  synchronous active-high clear, beats every other input
//    tx_valid  in   1  producer has a byte on tx_data
//    tx_data   in   8  byte to send, sampled only on acceptance
//    tx_ready  out  1  idle and able to accept a byte (registered)
//    tx        out  1  serial line, idle high (registered)
//    tx_done   out  1  one-cycle pulse in the final stop-bit cycle (registered)
// ============================================================================
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_done
);

    localparam int unsigned c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned c_BIT_W  = $clog2(DATA_BITS);

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                 r_state, w_state;
    logic [c_BAUD_W-1:0]    r_baud,  w_baud;
    logic [c_BIT_W-1:0]     r_bit,   w_bit;
    logic [DATA_BITS-1:0]   r_shift, w_shift;
    logic                   r_tx,    w_tx;
    logic                   r_ready, w_ready;
    logic                   r_done,  w_done;
    logic                   w_wrap;

    assign w_wrap = (r_baud == c_BAUD_LAST);

    // State and all outputs are registered; clr wins over everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_baud  <= w_baud;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_tx    <= w_tx;
            r_ready <= w_ready;
            r_done  <= w_done;
        end
    end

    // Next-state logic. The line value for the coming bit is computed at the
    // bit boundary so tx is a plain flop output and can only move on an edge.
    always_comb begin
        w_state = r_state;
        w_baud  = r_baud;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_tx    = r_tx;
        w_ready = r_ready;

        case (r_state)
            S_IDLE: begin
                w_baud  = '0;
                w_bit   = '0;
                w_tx    = 1'b1;
                w_ready = 1'b1;
                if (tx_valid) begin
                    w_shift = tx_data;
                    w_state = S_START;
                    w_tx    = 1'b0;
                    w_ready = 1'b0;
                end
            end
            S_START: begin
                if (w_wrap) begin
                    w_baud  = '0;
                    w_bit   = '0;
                    w_state = S_DATA;
                    w_tx    = r_shift[0];
                end else begin
                    w_baud  = r_baud + c_BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (w_wrap) begin
                    w_baud = '0;
                    if (r_bit == c_BIT_LAST) begin
                        w_bit   = '0;
                        w_state = S_STOP;
                        w_tx    = 1'b1;
                    end else begin
                        // Shift first so bit 0 of the register is always on the line.
                        w_bit   = r_bit + c_BIT_W'(1);
                        w_shift = r_shift >> 1;
                        w_tx    = r_shift[1];
                    end
                end else begin
                    w_baud = r_baud + c_BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (w_wrap) begin
                    w_baud  = '0;
                    w_state = S_IDLE;
                    w_tx    = 1'b1;
                    w_ready = 1'b1;
                end else begin
                    w_baud  = r_baud + c_BAUD_W'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
                w_baud  = '0;
                w_bit   = '0;
                w_tx    = 1'b1;
                w_ready = 1'b1;
            end
        endcase
    end

    // Registered done pulse: asserted for the cycle whose baud count is the
    // last one of the stop bit, i.e. decided from the next-state values.
    assign w_done = (w_state == S_STOP) && (w_baud == c_BAUD_LAST);

    assign tx_ready = r_ready;
    assign tx       = r_tx;
    assign tx_done  = r_done;

endmodule
`default_nettype wire
